// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared constants, sweep state encoding and helpers for the hsc TDC
package tdc_pkg;

    localparam logic PG_TOG = 1'b0;
    localparam logic PG_IN  = 1'b1;
    localparam logic REG    = 1'b0;
    localparam logic BYPASS = 1'b1;

    localparam int SWEEP_RST_CYC = 4;

    typedef enum logic [2:0] {
        IDLE,
        RESYNC,
        SETTLE,
        ACCUM,
        EMIT,
        BUMP,
        FIN
    } state_t;

    function automatic logic [3:0] clamp_slog2(input logic [3:0] v, input int max_slog2);
        return (32'(v) > max_slog2) ? 4'(max_slog2) : v;
    endfunction

endpackage

// File: rtl/tdc_step_acc.sv
// rtl/tdc_step_acc.sv - per-step sum/min/max accumulator over hamming-weight samples
module tdc_step_acc #(
    parameter int HW_W  = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [HW_W-1:0]  hw_in,
    output logic [ACC_W-1:0] sum,
    output logic [HW_W-1:0]  min,
    output logic [HW_W-1:0]  max
);

    logic [ACC_W-1:0] r_sum;
    logic [HW_W-1:0]  r_min;
    logic [HW_W-1:0]  r_max;

    // min resets to 0 so every result output reads 0 out of reset; clr seeds it with all ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
            r_min <= '0;
            r_max <= '0;
        end else if (clr) begin
            r_sum <= '0;
            r_min <= '1;
            r_max <= '0;
        end else if (en) begin
            r_sum <= r_sum + ACC_W'(hw_in);
            if (hw_in < r_min) r_min <= hw_in;
            if (hw_in > r_max) r_max <= hw_in;
        end
    end

    assign sum = r_sum;
    assign min = r_min;
    assign max = r_max;

endmodule

// File: rtl/tdc_sweep_ctrl.sv
// rtl/tdc_sweep_ctrl.sv - TDC phase-sweep sequencer: resync, settle, accumulate, emit, bump
module tdc_sweep_ctrl
    import tdc_pkg::*;
#(
    parameter int HW_W      = 8,
    parameter int MAX_SLOG2 = 8,
    parameter int STEP_W    = 10,
    parameter int RST_CYC   = SWEEP_RST_CYC,
    parameter int SETTLE_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      cfg_src,
    input  logic                      cfg_bypass,
    input  logic                      cfg_pg_in,
    input  logic [STEP_W-1:0]         cfg_steps,
    input  logic [3:0]                cfg_slog2,
    input  logic [SETTLE_W-1:0]       cfg_settle,
    input  logic [HW_W-1:0]           hw_in,
    output logic                      tdc_rst,
    output logic                      bump,
    output logic                      pg_src,
    output logic                      pg_bypass,
    output logic                      pg_in,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [STEP_W-1:0]         res_step,
    output logic [HW_W+MAX_SLOG2-1:0] res_sum,
    output logic [HW_W-1:0]           res_min,
    output logic [HW_W-1:0]           res_max,
    output logic                      busy,
    output logic                      done
);

    localparam int ACC_W  = HW_W + MAX_SLOG2;
    localparam int CNT_A  = (SETTLE_W > MAX_SLOG2 + 1) ? SETTLE_W : MAX_SLOG2 + 1;
    localparam int CNT_B  = $clog2(RST_CYC + 1);
    localparam int CNT_W  = ((CNT_A > CNT_B) ? CNT_A : CNT_B) + 1;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   r_steps;
    logic [3:0]          r_slog2;
    logic [SETTLE_W-1:0] r_settle;
    logic                r_pg_src;
    logic                r_pg_bypass;
    logic                r_pg_in;
    logic                r_done;

    logic                w_clr;
    logic                w_en;
    logic                w_accept;
    logic [CNT_W-1:0]    w_last_settle;
    logic [CNT_W-1:0]    w_last_acc;

    assign w_accept      = (r_state == IDLE) && start && !abort;
    assign w_last_settle = CNT_W'(r_settle) - CNT_W'(1);
    assign w_last_acc    = (CNT_W'(1) << r_slog2) - CNT_W'(1);

    always_comb begin
        w_next    = r_state;
        w_clr     = 1'b0;
        w_en      = 1'b0;
        tdc_rst   = 1'b0;
        bump      = 1'b0;
        res_valid = 1'b0;
        busy      = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = (cfg_steps == '0) ? FIN : RESYNC;
            end
            RESYNC: begin
                tdc_rst = 1'b1;
                if (r_cnt == CNT_W'(RST_CYC - 1)) begin
                    w_next = (r_settle == '0) ? ACCUM : SETTLE;
                    w_clr  = (r_settle == '0);
                end
            end
            SETTLE: begin
                if (r_cnt == w_last_settle) begin
                    w_next = ACCUM;
                    w_clr  = 1'b1;
                end
            end
            ACCUM: begin
                w_en = 1'b1;
                if (r_cnt == w_last_acc) w_next = EMIT;
            end
            EMIT: begin
                res_valid = 1'b1;
                if (res_ready) w_next = (r_step == r_steps - STEP_W'(1)) ? FIN : BUMP;
            end
            BUMP: begin
                bump   = 1'b1;
                w_next = (r_settle == '0) ? ACCUM : SETTLE;
                w_clr  = (r_settle == '0);
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // abort wins over every other transition, including the exit from EMIT
        if (abort && r_state != IDLE) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_step      <= '0;
            r_steps     <= '0;
            r_slog2     <= '0;
            r_settle    <= '0;
            r_pg_src    <= 1'b0;
            r_pg_bypass <= 1'b0;
            r_pg_in     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == FIN) && !abort;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == RESYNC || r_state == SETTLE || r_state == ACCUM)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_accept) begin
                r_step      <= '0;
                r_steps     <= cfg_steps;
                r_slog2     <= clamp_slog2(cfg_slog2, MAX_SLOG2);
                r_settle    <= cfg_settle;
                r_pg_src    <= cfg_src;
                r_pg_bypass <= cfg_bypass;
                r_pg_in     <= cfg_pg_in;
            end else if (r_state == BUMP) begin
                r_step <= r_step + STEP_W'(1);
            end
        end
    end

    tdc_step_acc #(
        .HW_W  (HW_W),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_en),
        .hw_in (hw_in),
        .sum   (res_sum),
        .min   (res_min),
        .max   (res_max)
    );

    assign res_step  = r_step;
    assign pg_src    = r_pg_src;
    assign pg_bypass = r_pg_bypass;
    assign pg_in     = r_pg_in;
    assign done      = r_done;

endmodule

// File: tb/tb_tdc_sweep_ctrl.sv
// tb/tb_tdc_sweep_ctrl.sv - directed self-checking bench for tdc_sweep_ctrl
module tb_tdc_sweep_ctrl;

    localparam int HW_W   = 8;
    localparam int STEP_W = 10;
    localparam int ACC_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              cfg_src = 1'b0;
    logic              cfg_bypass = 1'b0;
    logic              cfg_pg_in = 1'b0;
    logic [STEP_W-1:0] cfg_steps = '0;
    logic [3:0]        cfg_slog2 = '0;
    logic [7:0]        cfg_settle = '0;
    logic [HW_W-1:0]   hw_in;
    logic [HW_W-1:0]   hw_const = '0;
    logic              hw_ramp = 1'b0;
    logic [2:0]        ramp_cnt = '0;
    logic              res_ready = 1'b1;
    logic              tdc_rst, bump, pg_src, pg_bypass, pg_in, res_valid, busy, done;
    logic [STEP_W-1:0] res_step;
    logic [ACC_W-1:0]  res_sum;
    logic [HW_W-1:0]   res_min, res_max;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rst    = 0;
    int n_bump   = 0;
    int n_done   = 0;
    int q_step[$];
    int q_sum[$];
    int q_min[$];
    int q_max[$];

    tdc_sweep_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_src    (cfg_src),
        .cfg_bypass (cfg_bypass),
        .cfg_pg_in  (cfg_pg_in),
        .cfg_steps  (cfg_steps),
        .cfg_slog2  (cfg_slog2),
        .cfg_settle (cfg_settle),
        .hw_in      (hw_in),
        .tdc_rst    (tdc_rst),
        .bump       (bump),
        .pg_src     (pg_src),
        .pg_bypass  (pg_bypass),
        .pg_in      (pg_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_step   (res_step),
        .res_sum    (res_sum),
        .res_min    (res_min),
        .res_max    (res_max),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign hw_in = hw_ramp ? {5'b0, ramp_cnt} : hw_const;

    always @(posedge clk) begin
        #1;
        ramp_cnt = ramp_cnt + 3'd1;
    end

    always @(negedge clk) begin
        if (tdc_rst === 1'b1) n_rst++;
        if (bump === 1'b1) n_bump++;
        if (done === 1'b1) n_done++;
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            q_step.push_back(int'(res_step));
            q_sum.push_back(int'(res_sum));
            q_min.push_back(int'(res_min));
            q_max.push_back(int'(res_max));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int steps, input int slog2, input int settle);
        cfg_steps  = STEP_W'(steps);
        cfg_slog2  = 4'(slog2);
        cfg_settle = 8'(settle);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if ({busy, done, tdc_rst, bump, res_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, tdc_rst, bump, res_valid});
        end
        n_checks++;
        if (res_sum !== 16'd0 || res_min !== 8'd0 || res_max !== 8'd0 || res_step !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_res: got sum %0d min %0d max %0d step %0d expected all 0",
                     res_sum, res_min, res_max, res_step);
        end
        n_checks++;
        if ({pg_src, pg_bypass, pg_in} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_pg: got %b expected 000", {pg_src, pg_bypass, pg_in});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int base, r0, b0, d0, n;
        bit ok;
        base = q_sum.size(); r0 = n_rst; b0 = n_bump; d0 = n_done;
        cfg_src = 1'b1; cfg_bypass = 1'b1; cfg_pg_in = 1'b1;
        hw_const = 8'd5; res_ready = 1'b1;
        go(3, 2, 1);
        start = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, tdc_rst, pg_src, pg_bypass, pg_in} !== 5'b11111) begin
            n_fail++;
            $display("FAIL basic_first_cycle: got %b expected 11111", {busy, tdc_rst, pg_src, pg_bypass, pg_in});
        end
        tick();
        start = 1'b0;
        wait_done(200, ok);
        tick();
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: got no done expected done"); end
        n_checks++;
        if (n_rst - r0 !== 4) begin n_fail++; $display("FAIL basic_tdc_rst_cycles: got %0d expected 4", n_rst - r0); end
        n_checks++;
        if (n_bump - b0 !== 2) begin n_fail++; $display("FAIL basic_bumps: got %0d expected 2", n_bump - b0); end
        n_checks++;
        if (n_done - d0 !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", n_done - d0); end
        n = q_sum.size() - base;
        n_checks++;
        if (n !== 3) begin n_fail++; $display("FAIL basic_records: got %0d expected 3", n); end
        for (int k = 0; k < n && k < 3; k++) begin
            n_checks++;
            if (q_step[base+k] !== k || q_sum[base+k] !== 20 || q_min[base+k] !== 5 || q_max[base+k] !== 5) begin
                n_fail++;
                $display("FAIL basic_rec%0d: got step %0d sum %0d min %0d max %0d expected step %0d sum 20 min 5 max 5",
                         k, q_step[base+k], q_sum[base+k], q_min[base+k], q_max[base+k], k);
            end
        end
    endtask

    task automatic test_ramp();
        int base;
        bit ok;
        base = q_sum.size();
        hw_ramp = 1'b1;
        go(1, 3, 2);
        wait_done(200, ok);
        tick();
        hw_ramp = 1'b0;
        n_checks++;
        if (!ok || q_sum.size() - base !== 1) begin
            n_fail++;
            $display("FAIL ramp_records: got %0d records expected 1", q_sum.size() - base);
        end else begin
            n_checks++;
            if (q_sum[base] !== 28 || q_min[base] !== 0 || q_max[base] !== 7 || q_step[base] !== 0) begin
                n_fail++;
                $display("FAIL ramp_rec: got sum %0d min %0d max %0d step %0d expected 28 0 7 0",
                         q_sum[base], q_min[base], q_max[base], q_step[base]);
            end
        end
    endtask

    task automatic test_stall();
        int base, b0;
        bit ok, seen;
        base = q_sum.size(); b0 = n_bump;
        hw_const = 8'd3; res_ready = 1'b0;
        go(2, 2, 0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL stall_valid_timeout: got no res_valid expected res_valid"); end
        hw_const = 8'd9;
        for (int c = 0; c < 10; c++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || bump !== 1'b0 || res_sum !== 16'd12 || res_min !== 8'd3 ||
                res_max !== 8'd3 || res_step !== 10'd0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got valid %b bump %b sum %0d min %0d max %0d step %0d expected 1 0 12 3 3 0",
                         c, res_valid, bump, res_sum, res_min, res_max, res_step);
            end
        end
        res_ready = 1'b1;
        wait_done(100, ok);
        tick();
        n_checks++;
        if (!ok || q_sum.size() - base !== 2 || n_bump - b0 !== 1) begin
            n_fail++;
            $display("FAIL stall_resume: got records %0d bumps %0d expected 2 1", q_sum.size() - base, n_bump - b0);
        end else begin
            n_checks++;
            if (q_sum[base] !== 12 || q_step[base+1] !== 1 || q_sum[base+1] !== 36 ||
                q_min[base+1] !== 9 || q_max[base+1] !== 9) begin
                n_fail++;
                $display("FAIL stall_recs: got sum0 %0d step1 %0d sum1 %0d min1 %0d max1 %0d expected 12 1 36 9 9",
                         q_sum[base], q_step[base+1], q_sum[base+1], q_min[base+1], q_max[base+1]);
            end
        end
    endtask

    task automatic test_abort();
        int base, d0;
        bit seen;
        base = q_sum.size(); d0 = n_done;
        hw_const = 8'd1; res_ready = 1'b1;
        go(4, 2, 1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bump === 1'b1) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL abort_bump_timeout: got no bump expected bump"); end
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, res_valid, tdc_rst, bump, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got %b expected 00000", {busy, res_valid, tdc_rst, bump, done});
        end
        repeat (40) tick();
        n_checks++;
        if (q_sum.size() - base !== 1 || n_done - d0 !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_after: got records %0d dones %0d busy %b expected 1 0 0",
                     q_sum.size() - base, n_done - d0, busy);
        end
    endtask

    task automatic test_zero_steps();
        int base, r0, d0;
        base = q_sum.size(); r0 = n_rst; d0 = n_done;
        go(0, 2, 1);
        cfg_steps = 10'd3;
        start = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, tdc_rst} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_cycle1: got %b expected 100", {busy, done, tdc_rst});
        end
        tick();
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL zero_done_timing: got busy/done %b expected 01", {busy, done});
        end
        repeat (10) tick();
        n_checks++;
        if (n_rst - r0 !== 0 || q_sum.size() - base !== 0 || n_done - d0 !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: got rst %0d records %0d dones %0d busy %b expected 0 0 1 0",
                     n_rst - r0, q_sum.size() - base, n_done - d0, busy);
        end
    endtask

    task automatic test_start_abort();
        cfg_steps = 10'd2;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, tdc_rst} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_abort: got busy/tdc_rst %b expected 00", {busy, tdc_rst});
        end
        tick();
    endtask

    task automatic test_clamp();
        int base;
        bit ok;
        base = q_sum.size();
        hw_const = 8'd255; res_ready = 1'b1;
        go(1, 12, 0);
        wait_done(600, ok);
        tick();
        n_checks++;
        if (!ok || q_sum.size() - base !== 1) begin
            n_fail++;
            $display("FAIL clamp_records: got %0d records expected 1", q_sum.size() - base);
        end else begin
            n_checks++;
            if (q_sum[base] !== 65280 || q_min[base] !== 255 || q_max[base] !== 255) begin
                n_fail++;
                $display("FAIL clamp_rec: got sum %0d min %0d max %0d expected 65280 255 255",
                         q_sum[base], q_min[base], q_max[base]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = n_done;
        hw_const = 8'd4;
        go(2, 2, 1);
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, tdc_rst, pg_src} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_async: got busy/tdc_rst/pg_src %b expected 000", {busy, tdc_rst, pg_src});
        end
        tick();
        rst = 1'b0;
        repeat (20) tick();
        n_checks++;
        if (n_done - d0 !== 0 || busy !== 1'b0 || res_sum !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got dones %0d busy %b sum %0d expected 0 0 0",
                     n_done - d0, busy, res_sum);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ramp();
        test_stall();
        test_abort();
        test_zero_steps();
        test_start_abort();
        test_clamp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
